// File: rtl/snn_pkg.sv
// snn_pkg: shared widths, saturation limits and sequencer
// state encoding for the spiking-neuron datapath.
package snn_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 12;

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

endpackage

// File: rtl/lif_update.sv
// lif_update: leaky integrate-and-fire membrane update.
// Define LIF_SOFT_RESET_EN to subtract threshold on firing.
module lif_update
  import snn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic signed [DATA_W-1:0] v,
  input  logic signed [DATA_W-1:0] cur,
  input  logic signed [DATA_W-1:0] threshold,
  input  logic        [3:0]        leak_shift,
  output logic signed [DATA_W-1:0] v_next,
  output logic                     spike
);

  localparam int WW = DATA_W + 2;

  localparam logic signed [WW-1:0] MAX_W =
    WW'(SAT_MAX);
  localparam logic signed [WW-1:0] MIN_W =
    WW'(SAT_MIN);

  function automatic logic signed [DATA_W-1:0] sat(
    input logic signed [WW-1:0] x
  );
    logic signed [DATA_W-1:0] r;
    if (x > MAX_W) begin
      r = DATA_W'(SAT_MAX);
    end else if (x < MIN_W) begin
      r = DATA_W'(SAT_MIN);
    end else begin
      r = x[DATA_W-1:0];
    end
    return r;
  endfunction

  logic signed [WW-1:0]     v_w;
  logic signed [WW-1:0]     i_w;
  logic signed [WW-1:0]     leak_w;
  logic signed [WW-1:0]     sum_w;
  logic signed [DATA_W-1:0] v_sat;
`ifdef LIF_SOFT_RESET_EN
  logic signed [WW-1:0]     diff_w;
`endif

  always_comb begin
    v_w    = {{2{v[DATA_W-1]}}, v};
    i_w    = {{2{cur[DATA_W-1]}}, cur};
    leak_w = v_w >>> leak_shift;
    sum_w  = v_w - leak_w + i_w;
    v_sat  = sat(sum_w);
    spike  = (v_sat >= threshold);
`ifdef LIF_SOFT_RESET_EN
    diff_w = {{2{v_sat[DATA_W-1]}}, v_sat}
           - {{2{threshold[DATA_W-1]}}, threshold};
    v_next = spike ? sat(diff_w) : v_sat;
`else
    v_next = spike ? '0 : v_sat;
`endif
  end

endmodule

// File: rtl/lif_neuron_unit.sv
// lif_neuron_unit: sweeps N neurons per timestep, 3 cycles each.
// Firing behaviour selected by LIF_SOFT_RESET_EN (see lif_update).
module lif_neuron_unit
  import snn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  input  logic [ADDR_W-1:0] num_neurons,
  input  logic [DATA_W-1:0] threshold,
  input  logic [3:0]        leak_shift,
  input  logic [ADDR_W-1:0] cur_start_address,
  output logic [ADDR_W-1:0] cur_address,
  input  logic [DATA_W-1:0] cur_readdata,
  input  logic [ADDR_W-1:0] mem_start_address,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_write_en,
  input  logic [ADDR_W-1:0] spk_start_address,
  output logic [ADDR_W-1:0] spk_address,
  output logic [DATA_W-1:0] spk_writedata,
  output logic              spk_write_en
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]   spk_addr_q, spk_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   spk_wdata_q, spk_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic                spk_we_q, spk_we_d;

  logic signed [DATA_W-1:0] v_next;
  logic                     spike;
  logic                     last;

  lif_update #(
    .DATA_W     (DATA_W)
  ) u_update (
    .v          (mem_readdata),
    .cur        (cur_readdata),
    .threshold  (threshold),
    .leak_shift (leak_shift),
    .v_next     (v_next),
    .spike      (spike)
  );

  assign last = (idx_q == num_neurons - ADDR_W'(1));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cur_addr_d  = cur_addr_q;
    mem_addr_d  = mem_addr_q;
    spk_addr_d  = spk_addr_q;
    mem_wdata_d = mem_wdata_q;
    spk_wdata_d = spk_wdata_q;
    mem_we_d    = 1'b0;
    spk_we_d    = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start) begin
          idx_d   = '0;
          state_d = (num_neurons == '0) ? S_DONE : S_RD;
        end
      end
      (state_q == S_RD): begin
        cur_addr_d = cur_start_address + idx_q;
        mem_addr_d = mem_start_address + idx_q;
        state_d    = S_WAIT;
      end
      (state_q == S_WAIT): begin
        state_d = S_WR;
      end
      (state_q == S_WR): begin
        mem_we_d    = 1'b1;
        mem_wdata_d = v_next;
        spk_we_d    = 1'b1;
        spk_addr_d  = spk_start_address + idx_q;
        spk_wdata_d = {{(DATA_W-1){1'b0}}, spike};
        idx_d       = idx_q + ADDR_W'(1);
        state_d     = last ? S_DONE : S_RD;
      end
      (state_q == S_DONE): begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cur_addr_q  <= '0;
      mem_addr_q  <= '0;
      spk_addr_q  <= '0;
      mem_wdata_q <= '0;
      spk_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      spk_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cur_addr_q  <= cur_addr_d;
      mem_addr_q  <= mem_addr_d;
      spk_addr_q  <= spk_addr_d;
      mem_wdata_q <= mem_wdata_d;
      spk_wdata_q <= spk_wdata_d;
      mem_we_q    <= mem_we_d;
      spk_we_q    <= spk_we_d;
    end
  end

  assign done          = (state_q == S_DONE);
  assign cur_address   = cur_addr_q;
  assign mem_address   = mem_addr_q;
  assign spk_address   = spk_addr_q;
  assign mem_writedata = mem_wdata_q;
  assign spk_writedata = spk_wdata_q;
  assign mem_write_en  = mem_we_q;
  assign spk_write_en  = spk_we_q;

endmodule

// File: tb/tb_lif_neuron_unit.sv
// tb_lif_neuron_unit: directed and random timesteps against
// an arithmetic LIF model with behavioural SRAMs.
module tb_lif_neuron_unit;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          done;
  logic [AW-1:0] num_neurons = '0;
  logic [DW-1:0] threshold = '0;
  logic [3:0]    leak_shift = '0;
  logic [AW-1:0] cur_start_address = '0;
  logic [AW-1:0] cur_address;
  logic [DW-1:0] cur_readdata;
  logic [AW-1:0] mem_start_address = '0;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_readdata;
  logic [DW-1:0] mem_writedata;
  logic          mem_write_en;
  logic [AW-1:0] spk_start_address = '0;
  logic [AW-1:0] spk_address;
  logic [DW-1:0] spk_writedata;
  logic          spk_write_en;

  int checks = 0;
  int errors = 0;

  lif_neuron_unit #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .done              (done),
    .num_neurons       (num_neurons),
    .threshold         (threshold),
    .leak_shift        (leak_shift),
    .cur_start_address (cur_start_address),
    .cur_address       (cur_address),
    .cur_readdata      (cur_readdata),
    .mem_start_address (mem_start_address),
    .mem_address       (mem_address),
    .mem_readdata      (mem_readdata),
    .mem_writedata     (mem_writedata),
    .mem_write_en      (mem_write_en),
    .spk_start_address (spk_start_address),
    .spk_address       (spk_address),
    .spk_writedata     (spk_writedata),
    .spk_write_en      (spk_write_en)
  );

  always #5 clk = ~clk;

  // SRAM contents are preloaded; writes are only logged.
  logic [DW-1:0] cur_ram [DEPTH];
  logic [DW-1:0] mem_ram [DEPTH];
  logic [DW-1:0] cur_rd_q = '0;
  logic [DW-1:0] mem_rd_q = '0;
  logic [AW-1:0] mw_addr [$];
  logic [DW-1:0] mw_data [$];
  logic [AW-1:0] sw_addr [$];
  logic [DW-1:0] sw_data [$];

  assign cur_readdata = cur_rd_q;
  assign mem_readdata = mem_rd_q;

  always @(posedge clk) begin
    cur_rd_q <= cur_ram[cur_address];
    mem_rd_q <= mem_ram[mem_address];
    if (mem_write_en) begin
      mw_addr.push_back(mem_address);
      mw_data.push_back(mem_writedata);
    end
    if (spk_write_en) begin
      sw_addr.push_back(spk_address);
      sw_data.push_back(spk_writedata);
    end
  end

  int vv [16];
  int ii [16];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int sat16(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // Reference neuron: stored membrane value and spike flag.
  task automatic ref_neuron(input int v, input int i,
                            input int ls, input int thr,
                            output int stored,
                            output int spk);
    int vn;
    vn = sat16(v - (v >>> ls) + i);
    spk = (vn >= thr) ? 1 : 0;
`ifdef LIF_SOFT_RESET_EN
    stored = spk ? sat16(vn - thr) : vn;
`else
    stored = spk ? 0 : vn;
`endif
  endtask

  task automatic load(input int k, input int v, input int i);
    cur_ram[(int'(cur_start_address) + k) % DEPTH] = DW'(i);
    mem_ram[(int'(mem_start_address) + k) % DEPTH] = DW'(v);
    vv[k] = v;
    ii[k] = i;
  endtask

  task automatic config_step(input int n, input int thr,
                             input int ls, input int cb,
                             input int mb, input int sb);
    num_neurons       = AW'(n);
    threshold         = DW'(thr);
    leak_shift        = 4'(ls);
    cur_start_address = AW'(cb);
    mem_start_address = AW'(mb);
    spk_start_address = AW'(sb);
  endtask

  task automatic run_step(input int n, input int hold);
    int cyc;
    int bm;
    int bs;
    int st;
    int sp;
    int thr;
    bm = mw_addr.size();
    bs = sw_addr.size();
    thr = int'($signed(threshold));
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!done && cyc < 200);
    chk("done_latency", cyc, 3 * n + 1);
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("done_hold", done, 1);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("done_drop", done, 0);
    chk("mem_wr_count", mw_addr.size() - bm, n);
    chk("spk_wr_count", sw_addr.size() - bs, n);
    for (int k = 0; k < n; k++) begin
      if (bm + k < mw_addr.size() &&
          bs + k < sw_addr.size()) begin
        ref_neuron(vv[k], ii[k], int'(leak_shift), thr, st, sp);
        chk("mem_addr", mw_addr[bm + k],
            (int'(mem_start_address) + k) % DEPTH);
        chk("mem_data", mw_data[bm + k], st & 32'hFFFF);
        chk("spk_addr", sw_addr[bs + k],
            (int'(spk_start_address) + k) % DEPTH);
        chk("spk_data", sw_data[bs + k], sp);
      end
    end
  endtask

  initial begin
    int n;
    int bm;
    for (int a = 0; a < DEPTH; a++) begin
      cur_ram[a] = '0;
      mem_ram[a] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_mem_we", mem_write_en, 0);
    chk("rst_spk_we", spk_write_en, 0);
    chk("rst_cur_addr", cur_address, 0);
    chk("rst_mem_addr", mem_address, 0);
    chk("rst_spk_addr", spk_address, 0);
    chk("rst_mem_wdata", mem_writedata, 0);
    chk("rst_spk_wdata", spk_writedata, 0);
    @(negedge clk);
    reset = 1'b0;

    config_step(1, 200, 2, 16, 32, 48);
    load(0, 100, 50);
    run_step(1, 0);
    chk("basic_mem_125", mw_data[mw_data.size() - 1], 125);

    config_step(1, 200, 4, 100, 200, 300);
    load(0, 180, 60);
    run_step(1, 0);
    chk("fire_spk", sw_data[sw_data.size() - 1], 1);

    config_step(2, 32767, 15, 500, 600, 700);
    load(0, 32000, 32000);
    load(1, -32768, -32768);
    run_step(2, 0);
    chk("neg_sat", mw_data[mw_data.size() - 1], 16'h8000);

    config_step(4, 10, 1, 1000, 2000, 3000);
    for (int k = 0; k < 4; k++) load(k, 20 * k - 30, 7 * k);
    run_step(4, 5);

    config_step(0, 0, 0, 0, 0, 0);
    run_step(0, 2);

    config_step(4, 50, 3, 10, 20, 30);
    for (int k = 0; k < 4; k++) load(k, 40 * k, 5);
    bm = mw_addr.size();
    @(negedge clk);
    start = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_done", done, 0);
    chk("abort_mem_we", mem_write_en, 0);
    chk("abort_mem_addr", mem_address, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_writes", mw_addr.size() - bm, 2);
    chk("abort_idle_done", done, 0);

    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(1, 6));
      config_step(n, int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 15)),
                  (r == 0) ? 4094 : int'($urandom_range(0, 4095)),
                  int'($urandom_range(0, 4095)),
                  (r == 1) ? 4093 : int'($urandom_range(0, 4095)));
      for (int k = 0; k < n; k++) begin
        load(k, int'($urandom_range(0, 65535)) - 32768,
             int'($urandom_range(0, 65535)) - 32768);
      end
      run_step(n, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
